// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// serves two decode read ports with same-cycle bypass, and counts committed writes.
module wb_regfile #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 32
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [1:0]       SelWB_W,
   input  logic             WEN_W,
   input  logic [DW-1:0]    ALUOUT_W,
   input  logic [DW-1:0]    LoadData_W,
   input  logic [DW-1:0]    PCADD4_W,
   input  logic [DW-1:0]    DOUT0_W,
   input  logic [AW-1:0]    WA_W,
   input  logic [AW-1:0]    RA0,
   input  logic [AW-1:0]    RA1,
   output logic [DW-1:0]    RD0,
   output logic [DW-1:0]    RD1,
   output logic [DW-1:0]    WB_DATA,
   output logic             WB_FIRE,
   output logic [CNT_W-1:0] WCNT
);

   localparam int   LP_NREG = 2**AW;
   localparam logic LP_ZR   = (ZERO_REG != 0);

   logic [DW-1:0]    r_regs [LP_NREG];
   logic [CNT_W-1:0] r_wcnt;
   logic [DW-1:0]    w_wb_data;
   logic             w_fire;

   always_comb begin
      w_wb_data = ALUOUT_W;
      case (SelWB_W)
         2'd0:    w_wb_data = ALUOUT_W;
         2'd1:    w_wb_data = LoadData_W;
         2'd2:    w_wb_data = PCADD4_W;
         2'd3:    w_wb_data = DOUT0_W;
         default: w_wb_data = ALUOUT_W;
      endcase
   end

   // RSTN in the fire term gates both the commit and the bypass while in reset.
   assign w_fire = ~WEN_W & ~(LP_ZR & (WA_W == '0)) & RSTN;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < LP_NREG; i++) r_regs[i] <= '0;
      end else if (w_fire) begin
         r_regs[WA_W] <= w_wb_data;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)       r_wcnt <= '0;
      else if (w_fire) r_wcnt <= r_wcnt + CNT_W'(1);
   end

   always_comb begin
      RD0 = r_regs[RA0];
      if (LP_ZR && (RA0 == '0))          RD0 = '0;
      else if (w_fire && (WA_W == RA0))  RD0 = w_wb_data;
   end

   always_comb begin
      RD1 = r_regs[RA1];
      if (LP_ZR && (RA1 == '0))          RD1 = '0;
      else if (w_fire && (WA_W == RA1))  RD1 = w_wb_data;
   end

   assign WB_DATA = w_wb_data;
   assign WB_FIRE = w_fire;
   assign WCNT    = r_wcnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: three instances share stimulus (default,
// ZERO_REG=0, CNT_W=4) so zero-register and counter-wrap behaviour are covered.
module tb_wb_regfile;

   logic        CLK;
   logic        RSTN;
   logic [1:0]  SelWB_W;
   logic        WEN_W;
   logic [31:0] ALUOUT_W, LoadData_W, PCADD4_W, DOUT0_W;
   logic [4:0]  WA_W, RA0, RA1;

   logic [31:0] rd0_a, rd1_a, wbd_a, wcnt_a;
   logic        fire_a;
   logic [31:0] rd0_z, rd1_z, wbd_z, wcnt_z;
   logic        fire_z;
   logic [31:0] rd0_c, rd1_c, wbd_c;
   logic        fire_c;
   logic [3:0]  wcnt_c;

   int checks = 0;
   int failures = 0;

   wb_regfile #(.DW(32), .AW(5), .ZERO_REG(1), .CNT_W(32)) u_dut (
      .CLK(CLK), .RSTN(RSTN), .SelWB_W(SelWB_W), .WEN_W(WEN_W),
      .ALUOUT_W(ALUOUT_W), .LoadData_W(LoadData_W), .PCADD4_W(PCADD4_W),
      .DOUT0_W(DOUT0_W), .WA_W(WA_W), .RA0(RA0), .RA1(RA1),
      .RD0(rd0_a), .RD1(rd1_a), .WB_DATA(wbd_a), .WB_FIRE(fire_a), .WCNT(wcnt_a)
   );

   wb_regfile #(.DW(32), .AW(5), .ZERO_REG(0), .CNT_W(32)) u_dut_z0 (
      .CLK(CLK), .RSTN(RSTN), .SelWB_W(SelWB_W), .WEN_W(WEN_W),
      .ALUOUT_W(ALUOUT_W), .LoadData_W(LoadData_W), .PCADD4_W(PCADD4_W),
      .DOUT0_W(DOUT0_W), .WA_W(WA_W), .RA0(RA0), .RA1(RA1),
      .RD0(rd0_z), .RD1(rd1_z), .WB_DATA(wbd_z), .WB_FIRE(fire_z), .WCNT(wcnt_z)
   );

   wb_regfile #(.DW(32), .AW(5), .ZERO_REG(1), .CNT_W(4)) u_dut_c4 (
      .CLK(CLK), .RSTN(RSTN), .SelWB_W(SelWB_W), .WEN_W(WEN_W),
      .ALUOUT_W(ALUOUT_W), .LoadData_W(LoadData_W), .PCADD4_W(PCADD4_W),
      .DOUT0_W(DOUT0_W), .WA_W(WA_W), .RA0(RA0), .RA1(RA1),
      .RD0(rd0_c), .RD1(rd1_c), .WB_DATA(wbd_c), .WB_FIRE(fire_c), .WCNT(wcnt_c)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and land 1 ns after it, clear of the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [1:0] sel, input logic [4:0] wa, input logic [31:0] val);
      WEN_W = 1'b0; SelWB_W = sel; WA_W = wa;
      ALUOUT_W = 32'h0; LoadData_W = 32'h0; PCADD4_W = 32'h0; DOUT0_W = 32'h0;
      case (sel)
         2'd0: ALUOUT_W   = val;
         2'd1: LoadData_W = val;
         2'd2: PCADD4_W   = val;
         default: DOUT0_W = val;
      endcase
   endtask

   initial begin
      RSTN = 1'b0; WEN_W = 1'b0; SelWB_W = 2'd0; WA_W = 5'd9;
      ALUOUT_W = 32'h1234_5678; LoadData_W = 32'h0; PCADD4_W = 32'h0; DOUT0_W = 32'h0;
      RA0 = 5'd9; RA1 = 5'd9;
      #2;
      chk("rst_fire_gated", {31'b0, fire_a}, 32'h0);
      chk("rst_rd0_no_bypass", rd0_a, 32'h0);
      tick();
      chk("rst_wcnt_held", wcnt_a, 32'h0);
      WEN_W = 1'b1;
      tick();
      RSTN = 1'b1;
      #1;
      chk("post_rst_fire", {31'b0, fire_a}, 32'h0);
      chk("post_rst_wcnt", wcnt_a, 32'h0);
      for (int i = 0; i < 32; i++) begin
         RA0 = 5'(i); RA1 = 5'(31 - i);
         #1;
         chk($sformatf("post_rst_rd0_r%0d", i), rd0_a, 32'h0);
         chk($sformatf("post_rst_rd1_r%0d", 31 - i), rd1_a, 32'h0);
      end

      // Basic ALU write, seen through the array one cycle later
      tick();
      wr(2'd0, 5'd5, 32'hDEAD_BEEF); RA0 = 5'd3;
      #1;
      chk("t2_wb_data", wbd_a, 32'hDEAD_BEEF);
      chk("t2_fire", {31'b0, fire_a}, 32'h1);
      tick();
      WEN_W = 1'b1; RA0 = 5'd5;
      #1;
      chk("t2_rd0_r5", rd0_a, 32'hDEAD_BEEF);
      chk("t2_wcnt", wcnt_a, 32'd1);

      // Same-cycle bypass on port 1
      wr(2'd2, 5'd7, 32'h0000_0104); RA1 = 5'd7;
      #1;
      chk("t3_bypass_rd1", rd1_a, 32'h0000_0104);
      chk("t3_rd0_unaffected", rd0_a, 32'hDEAD_BEEF);
      tick();
      WEN_W = 1'b1;
      #1;
      chk("t3_array_rd1", rd1_a, 32'h0000_0104);
      chk("t3_wcnt", wcnt_a, 32'd2);

      // r0 writes: ignored with ZERO_REG=1, ordinary with ZERO_REG=0
      wr(2'd0, 5'd0, 32'h0000_0055); RA0 = 5'd0; RA1 = 5'd0;
      #1;
      chk("t4_zr_fire", {31'b0, fire_a}, 32'h0);
      chk("t4_zr_rd0", rd0_a, 32'h0);
      chk("t4_z0_fire", {31'b0, fire_z}, 32'h1);
      chk("t4_z0_bypass", rd0_z, 32'h0000_0055);
      tick();
      WEN_W = 1'b1;
      #1;
      chk("t4_zr_rd0_after", rd0_a, 32'h0);
      chk("t4_zr_wcnt", wcnt_a, 32'd2);
      chk("t4_z0_rd0_after", rd0_z, 32'h0000_0055);
      chk("t4_z0_rd1_after", rd1_z, 32'h0000_0055);
      chk("t4_z0_wcnt", wcnt_z, 32'd3);

      // Source sweep, then idle cycles with X on select/address
      wr(2'd1, 5'd1, 32'h0000_0011);
      tick();
      wr(2'd3, 5'd2, 32'h0000_0033);
      tick();
      WEN_W = 1'b1; SelWB_W = 2'bxx; WA_W = 5'bxxxxx;
      RA0 = 5'd1; RA1 = 5'd2;
      #1;
      chk("t5_fire_x_idle", {31'b0, fire_a}, 32'h0);
      tick();
      tick();
      chk("t5_reg1", rd0_a, 32'h0000_0011);
      chk("t5_reg2", rd1_a, 32'h0000_0033);
      chk("t5_wcnt", wcnt_a, 32'd4);

      // Back-to-back writes to one address: last wins, both count
      wr(2'd0, 5'd3, 32'h0000_00A1);
      tick();
      wr(2'd0, 5'd3, 32'h0000_00A2);
      tick();
      WEN_W = 1'b1; RA0 = 5'd3; RA1 = 5'd3;
      #1;
      chk("t5b_last_wins_rd0", rd0_a, 32'h0000_00A2);
      chk("t5b_same_ra_rd1", rd1_a, 32'h0000_00A2);
      chk("t5b_wcnt", wcnt_a, 32'd6);

      // Fill r1..r31, then reset between edges with a write pending
      for (int i = 1; i < 32; i++) begin
         wr(2'd0, 5'(i), 32'h100 + 32'(i));
         tick();
      end
      WEN_W = 1'b1; RA0 = 5'd31; RA1 = 5'd16;
      #1;
      chk("t6_fill_r31", rd0_a, 32'h0000_011F);
      chk("t6_fill_r16", rd1_a, 32'h0000_0110);
      chk("t6_fill_wcnt", wcnt_a, 32'd37);
      tick();
      wr(2'd0, 5'd4, 32'hCAFE_F00D);
      #1;
      RSTN = 1'b0;
      #1;
      chk("t6_rst_fire", {31'b0, fire_a}, 32'h0);
      chk("t6_rst_wcnt_async", wcnt_a, 32'h0);
      WEN_W = 1'b1;
      #1;
      RSTN = 1'b1;
      tick();
      chk("t6_wcnt_after", wcnt_a, 32'h0);
      chk("t6_c4_wcnt_after", {28'b0, wcnt_c}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         RA0 = 5'(i); RA1 = 5'(i);
         #1;
         chk($sformatf("t6_cleared_rd0_r%0d", i), rd0_a, 32'h0);
         chk($sformatf("t6_cleared_rd1_r%0d", i), rd1_a, 32'h0);
      end

      // 17 writes: 4-bit counter wraps 15 -> 0 -> 1
      for (int i = 0; i < 17; i++) begin
         wr(2'd0, 5'((i % 31) + 1), 32'(i));
         tick();
      end
      WEN_W = 1'b1;
      #1;
      chk("t6_c4_wrap", {28'b0, wcnt_c}, 32'd1);
      chk("t6_main_wcnt_17", wcnt_a, 32'd17);
      chk("t6_z0_wcnt_17", wcnt_z, 32'd17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
